// File: rtl/caliptra_sram_ldr_pkg.sv
// rtl/caliptra_sram_ldr_pkg.sv - shared types for the SRAM preload arbiter
package caliptra_sram_ldr_pkg;

    // Entry fields are sized for the widest supported configuration; users slice them down.
    localparam int LDR_CH_MAX_W   = 3;
    localparam int LDR_ADDR_MAX_W = 32;
    localparam int LDR_DATA_MAX_W = 64;

    localparam logic [31:0] LDR_CNT_SAT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [LDR_CH_MAX_W-1:0]   ch;
        logic [LDR_ADDR_MAX_W-1:0] addr;
        logic [LDR_DATA_MAX_W-1:0] wdata;
        logic                      last;
    } ldr_entry_t;

    typedef enum logic [1:0] {
        LDR_IDLE   = 2'd0,
        LDR_ACTIVE = 2'd1,
        LDR_FLUSH  = 2'd2,
        LDR_DONE   = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/caliptra_sram_ldr_fifo.sv
// rtl/caliptra_sram_ldr_fifo.sv - in-order preload entry buffer with head peek
module caliptra_sram_ldr_fifo
    import caliptra_sram_ldr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       push,
    input  ldr_entry_t push_data,
    input  logic       pop,
    output ldr_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    ldr_entry_t    mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/caliptra_sram_loader_arb.sv
// rtl/caliptra_sram_loader_arb.sv - SRAM front-end draining preload writes around DUT traffic (CALIPTRA_SRAM_BITFLIP_INJ_EN)
module caliptra_sram_loader_arb
    import caliptra_sram_ldr_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 39,
    parameter int ADDR_WIDTH = 15,
    parameter int FIFO_DEPTH = 4,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                                 clk,
    input  logic                                 cptra_rst_b,
    input  logic                                 ext_valid,
    output logic                                 ext_ready,
    input  logic [CH_W-1:0]                      ext_ch,
    input  logic [ADDR_WIDTH-1:0]                ext_addr,
    input  logic [DATA_WIDTH-1:0]                ext_wdata,
    input  logic                                 ext_last,
    input  logic [NUM_CH-1:0]                    dut_cs,
    input  logic [NUM_CH-1:0]                    dut_we,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    dut_addr,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]    dut_wdata,
    output logic [NUM_CH-1:0]                    sram_cs,
    output logic [NUM_CH-1:0]                    sram_we,
    output logic [NUM_CH-1:0][ADDR_WIDTH-1:0]    sram_addr,
    output logic [NUM_CH-1:0][DATA_WIDTH-1:0]    sram_wdata,
    input  logic                                 flip_arm,
    input  logic [CH_W-1:0]                      flip_ch,
    input  logic [DATA_WIDTH-1:0]                flip_mask,
    output logic [NUM_CH-1:0]                    flip_pending,
    output logic                                 load_busy,
    output logic                                 load_done,
    output logic [31:0]                          load_cnt
);

    ldr_entry_t                         push_entry;
    ldr_entry_t                         head;
    logic                               fifo_full;
    logic                               fifo_empty;
    logic                               push;
    logic                               drain;
    logic                               cnt_inc;
    logic                               head_cs_busy;
    logic                               head_known;
    logic [NUM_CH-1:0]                  head_hit;
    logic [NUM_CH-1:0][DATA_WIDTH-1:0]  flip_xor;
    logic                               session_start;
    ldr_state_e                         state_q;
    ldr_state_e                         state_d;
    logic                               unused_head;

    assign ext_ready = !fifo_full;
    assign push      = ext_valid && ext_ready;

    always_comb begin
        push_entry       = '0;
        push_entry.ch    = LDR_CH_MAX_W'(ext_ch);
        push_entry.addr  = LDR_ADDR_MAX_W'(ext_addr);
        push_entry.wdata = LDR_DATA_MAX_W'(ext_wdata);
        push_entry.last  = ext_last;
    end

    caliptra_sram_ldr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_b     (cptra_rst_b),
        .push      (push),
        .push_data (push_entry),
        .pop       (drain),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        head_hit     = '0;
        head_cs_busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            head_hit[c] = (head.ch == LDR_CH_MAX_W'(c));
            if (head_hit[c]) begin
                head_cs_busy = dut_cs[c];
            end
        end
    end

    // An entry aimed at a nonexistent channel is discarded rather than blocking the queue.
    assign head_known = |head_hit;
    assign drain      = cptra_rst_b && !fifo_empty && !head_cs_busy;
    assign cnt_inc    = drain && head_known;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            sram_cs[c]    = 1'b0;
            sram_we[c]    = 1'b0;
            sram_addr[c]  = '0;
            sram_wdata[c] = '0;
            if (dut_cs[c]) begin
                sram_cs[c]    = 1'b1;
                sram_we[c]    = dut_we[c];
                sram_addr[c]  = dut_addr[c];
                sram_wdata[c] = dut_wdata[c] ^ flip_xor[c];
            end else if (drain && head_hit[c]) begin
                sram_cs[c]    = 1'b1;
                sram_we[c]    = 1'b1;
                sram_addr[c]  = head.addr[ADDR_WIDTH-1:0];
                sram_wdata[c] = head.wdata[DATA_WIDTH-1:0];
            end
        end
    end

`ifdef CALIPTRA_SRAM_BITFLIP_INJ_EN
    logic [NUM_CH-1:0][DATA_WIDTH-1:0] mask_q;
    logic [NUM_CH-1:0]                 pending_q;
    logic [NUM_CH-1:0]                 consume;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            consume[c]  = pending_q[c] && dut_cs[c] && dut_we[c];
            flip_xor[c] = consume[c] ? mask_q[c] : '0;
        end
    end

    // A fresh arm wins over a same-cycle consume so the new mask stays pending.
    always_ff @(posedge clk) begin
        if (!cptra_rst_b) begin
            mask_q    <= '0;
            pending_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (flip_arm && (flip_ch == CH_W'(c))) begin
                    mask_q[c]    <= flip_mask;
                    pending_q[c] <= 1'b1;
                end else if (consume[c]) begin
                    pending_q[c] <= 1'b0;
                end
            end
        end
    end

    assign flip_pending = pending_q;
`else
    logic unused_flip;

    assign flip_xor     = '0;
    assign flip_pending = '0;
    assign unused_flip  = ^{flip_arm, flip_ch, flip_mask};
`endif

    assign unused_head = ^{head.ch, head.addr, head.wdata, head.last};

    always_ff @(posedge clk) begin
        if (!cptra_rst_b) begin
            state_q <= LDR_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        session_start = 1'b0;
        case (state_q)
            LDR_IDLE: begin
                if (push) begin
                    session_start = 1'b1;
                    state_d       = ext_last ? LDR_FLUSH : LDR_ACTIVE;
                end
            end
            LDR_ACTIVE: begin
                if (push && ext_last) begin
                    state_d = LDR_FLUSH;
                end
            end
            LDR_FLUSH: begin
                if (fifo_empty && !push) begin
                    state_d = LDR_DONE;
                end
            end
            LDR_DONE: begin
                state_d = LDR_IDLE;
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cptra_rst_b) begin
            load_cnt <= '0;
        end else if (session_start) begin
            load_cnt <= '0;
        end else if (cnt_inc && (load_cnt != LDR_CNT_SAT)) begin
            load_cnt <= load_cnt + 32'd1;
        end
    end

    assign load_busy = (state_q == LDR_ACTIVE) || (state_q == LDR_FLUSH);
    assign load_done = (state_q == LDR_DONE);

endmodule

// File: tb/tb_caliptra_sram_loader_arb.sv
// tb/tb_caliptra_sram_loader_arb.sv - directed self-checking bench for caliptra_sram_loader_arb
module tb_caliptra_sram_loader_arb;

`ifdef CALIPTRA_SRAM_BITFLIP_INJ_EN
    localparam bit FLIP = 1'b1;
`else
    localparam bit FLIP = 1'b0;
`endif

    logic              clk;
    logic              cptra_rst_b;
    logic              ext_valid;
    logic              ext_ready;
    logic [0:0]        ext_ch;
    logic [14:0]       ext_addr;
    logic [38:0]       ext_wdata;
    logic              ext_last;
    logic [1:0]        dut_cs;
    logic [1:0]        dut_we;
    logic [1:0][14:0]  dut_addr;
    logic [1:0][38:0]  dut_wdata;
    logic [1:0]        sram_cs;
    logic [1:0]        sram_we;
    logic [1:0][14:0]  sram_addr;
    logic [1:0][38:0]  sram_wdata;
    logic              flip_arm;
    logic [0:0]        flip_ch;
    logic [38:0]       flip_mask;
    logic [1:0]        flip_pending;
    logic              load_busy;
    logic              load_done;
    logic [31:0]       load_cnt;

    int vectors;
    int miscompares;

    caliptra_sram_loader_arb dut (
        .clk          (clk),
        .cptra_rst_b  (cptra_rst_b),
        .ext_valid    (ext_valid),
        .ext_ready    (ext_ready),
        .ext_ch       (ext_ch),
        .ext_addr     (ext_addr),
        .ext_wdata    (ext_wdata),
        .ext_last     (ext_last),
        .dut_cs       (dut_cs),
        .dut_we       (dut_we),
        .dut_addr     (dut_addr),
        .dut_wdata    (dut_wdata),
        .sram_cs      (sram_cs),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .flip_arm     (flip_arm),
        .flip_ch      (flip_ch),
        .flip_mask    (flip_mask),
        .flip_pending (flip_pending),
        .load_busy    (load_busy),
        .load_done    (load_done),
        .load_cnt     (load_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_word(input logic ch, input logic [14:0] a, input logic [38:0] d, input logic l);
        ext_valid = 1'b1;
        ext_ch    = ch;
        ext_addr  = a;
        ext_wdata = d;
        ext_last  = l;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        cptra_rst_b = 1'b0;
        ext_valid = 1'b0; ext_ch = '0; ext_addr = '0; ext_wdata = '0; ext_last = 1'b0;
        dut_cs = '0; dut_we = '0; dut_addr = '0; dut_wdata = '0;
        flip_arm = 1'b0; flip_ch = '0; flip_mask = '0;
        repeat (2) step();
        cptra_rst_b = 1'b1;
        settle();
        chk("rst_ready", ext_ready, 1);
        chk("rst_busy", load_busy, 0);
        chk("rst_done", load_done, 0);
        chk("rst_cnt", load_cnt, 0);
        chk("rst_pending", flip_pending, 0);
        chk("rst_sram_cs", sram_cs, 0);
        step();

        // 8-word preload to ch0, drains one cycle behind each push
        for (int i = 0; i < 8; i++) begin
            push_word(1'b0, 15'(i), 39'h100 + 39'(i), i == 7);
            settle();
            if (i > 0) begin
                chk("t1_cs", sram_cs, 2'b01);
                chk("t1_we", sram_we, 2'b01);
                chk("t1_addr", sram_addr[0], 64'(i - 1));
                chk("t1_data", sram_wdata[0], 64'h100 + 64'(i - 1));
            end else begin
                chk("t1_first_cs", sram_cs, 2'b00);
            end
            step();
        end
        ext_valid = 1'b0; ext_last = 1'b0;
        settle();
        chk("t1_last_addr", sram_addr[0], 7);
        chk("t1_last_cs", sram_cs, 2'b01);
        chk("t1_busy", load_busy, 1);
        step();
        chk("t1_idle_cs", sram_cs, 0);
        chk("t1_cnt", load_cnt, 8);
        chk("t1_nodone", load_done, 0);
        step();
        chk("t1_done", load_done, 1);
        chk("t1_busy_low", load_busy, 0);
        step();
        chk("t1_done_once", load_done, 0);
        chk("t1_cnt_hold", load_cnt, 8);
        step();

        // DUT holds ch1 for 10 cycles while ch1 entries queue up
        dut_cs = 2'b10; dut_we = 2'b00; dut_addr[1] = 15'h55;
        for (int i = 0; i < 10; i++) begin
            if (i < 5) push_word(1'b1, 15'h10 + 15'(i), 39'h200 + 39'(i), i == 3);
            else begin ext_valid = 1'b0; ext_last = 1'b0; end
            settle();
            chk("t2_ready", ext_ready, (i < 4) ? 1 : 0);
            chk("t2_cs", sram_cs, 2'b10);
            chk("t2_we", sram_we, 2'b00);
            chk("t2_dut_addr", sram_addr[1], 15'h55);
            step();
        end
        dut_cs = 2'b00;
        for (int i = 0; i < 4; i++) begin
            settle();
            if (i == 0) chk("t2_cnt_pre", load_cnt, 0);
            chk("t2_cs", sram_cs, 2'b10);
            chk("t2_we", sram_we, 2'b10);
            chk("t2_addr", sram_addr[1], 64'h10 + 64'(i));
            chk("t2_data", sram_wdata[1], 64'h200 + 64'(i));
            step();
        end
        chk("t2_empty_cs", sram_cs, 0);
        step();
        chk("t2_done", load_done, 1);
        chk("t2_cnt", load_cnt, 4);
        step();

        // interleaved channels while DUT reads ch0
        dut_cs = 2'b01; dut_we = 2'b00; dut_addr[0] = 15'h33; dut_addr[1] = '0;
        push_word(1'b1, 15'h20, 39'h300, 1'b0);
        settle();
        chk("t3_c0_cs", sram_cs, 2'b01);
        step();
        push_word(1'b0, 15'h21, 39'h301, 1'b0);
        settle();
        chk("t3_c1_cs", sram_cs, 2'b11);
        chk("t3_c1_we", sram_we, 2'b10);
        chk("t3_c1_addr1", sram_addr[1], 15'h20);
        chk("t3_c1_rd_addr", sram_addr[0], 15'h33);
        step();
        push_word(1'b1, 15'h22, 39'h302, 1'b1);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t3_stall_cs", sram_cs, 2'b01);
            chk("t3_stall_we", sram_we, 2'b00);
            chk("t3_stall_addr", sram_addr[0], 15'h33);
            step();
            ext_valid = 1'b0; ext_last = 1'b0;
        end
        dut_cs = 2'b00;
        settle();
        chk("t3_b_cs", sram_cs, 2'b01);
        chk("t3_b_we", sram_we, 2'b01);
        chk("t3_b_addr", sram_addr[0], 15'h21);
        chk("t3_b_data", sram_wdata[0], 39'h301);
        step();
        chk("t3_c_cs", sram_cs, 2'b10);
        chk("t3_c_addr", sram_addr[1], 15'h22);
        step();
        chk("t3_idle_cs", sram_cs, 0);
        step();
        chk("t3_done", load_done, 1);
        chk("t3_cnt", load_cnt, 3);
        step();

        // reset with three stalled entries buffered
        dut_cs = 2'b01;
        for (int i = 0; i < 3; i++) begin
            push_word(1'b0, 15'h40 + 15'(i), 39'h400 + 39'(i), 1'b0);
            step();
        end
        ext_valid = 1'b0;
        dut_cs = 2'b00;
        cptra_rst_b = 1'b0;
        settle();
        chk("t4_rst_cs", sram_cs, 0);
        step();
        cptra_rst_b = 1'b1;
        settle();
        chk("t4_ready", ext_ready, 1);
        chk("t4_cnt", load_cnt, 0);
        chk("t4_busy", load_busy, 0);
        chk("t4_cs", sram_cs, 0);
        step();
        chk("t4_cs_after", sram_cs, 0);
        step();

        // bitflip injection (inert when the feature is compiled out)
        flip_arm = 1'b1; flip_ch = 1'b0; flip_mask = 39'h1;
        settle();
        chk("t5_pend_pre", flip_pending, 0);
        step();
        flip_arm = 1'b0;
        dut_cs = 2'b01; dut_we = 2'b01; dut_wdata[0] = '0;
        settle();
        chk("t5_pend_armed", flip_pending, FLIP ? 2'b01 : 2'b00);
        chk("t5_flip_data", sram_wdata[0], FLIP ? 1 : 0);
        step();
        settle();
        chk("t5_pend_clr", flip_pending, 0);
        chk("t5_second_data", sram_wdata[0], 0);
        step();
        dut_cs = 2'b00; dut_we = 2'b00;
        flip_arm = 1'b1; flip_mask = 39'h1;
        step();
        flip_arm = 1'b0;
        push_word(1'b0, 15'h50, 39'h7, 1'b1);
        step();
        ext_valid = 1'b0; ext_last = 1'b0;
        settle();
        chk("t5_drain_cs", sram_cs, 2'b01);
        chk("t5_drain_data", sram_wdata[0], 39'h7);
        chk("t5_drain_pend", flip_pending, FLIP ? 2'b01 : 2'b00);
        step();
        dut_cs = 2'b01; dut_we = 2'b01; dut_wdata[0] = '0;
        flip_arm = 1'b1; flip_mask = 39'h2;
        settle();
        chk("t5_same_cyc_data", sram_wdata[0], FLIP ? 1 : 0);
        step();
        flip_arm = 1'b0; dut_cs = 2'b00; dut_we = 2'b00;
        settle();
        chk("t5_rearm_pend", flip_pending, FLIP ? 2'b01 : 2'b00);
        step();
        dut_cs = 2'b01; dut_we = 2'b01;
        settle();
        chk("t5_new_mask_data", sram_wdata[0], FLIP ? 2 : 0);
        step();
        dut_cs = 2'b00; dut_we = 2'b00;
        settle();
        chk("t5_final_pend", flip_pending, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/caliptra_sram_loader_arb.md
Name: caliptra_sram_loader_arb

Overview:
- Parametrised multi-channel SRAM front-end for the verilated and emulation top levels.
- Replaces the ad-hoc per-memory backdoor mux (DUT port vs. external C++ write) and fixed wdata bitflip XOR.
- Buffers an external preload write stream tagged with a channel, drains it into N SRAM ports only when the DUT is not using them, tracks load completion, and optionally injects one-shot bitflips on DUT writes for ECC testing.

Parameters:
- NUM_CH, 2, number of SRAM channels (1..8).
- DATA_WIDTH, 39, SRAM word width including ECC bits.
- ADDR_WIDTH, 15, SRAM word address width.
- FIFO_DEPTH, 4, preload buffer entries (power of two, >=2).
- CH_W, $clog2(NUM_CH) min 1, derived channel index width.

Ports:
- clk  in  1  clock
- cptra_rst_b  in  1  synchronous active-low reset
- ext_valid  in  1  preload write request
- ext_ready  out  1  preload buffer can accept
- ext_ch  in  CH_W  target channel
- ext_addr  in  ADDR_WIDTH  word address
- ext_wdata  in  DATA_WIDTH  write data
- ext_last  in  1  marks final word of a load session
- dut_cs  in  NUM_CH  DUT chip select per channel
- dut_we  in  NUM_CH  DUT write enable per channel
- dut_addr  in  NUM_CH x ADDR_WIDTH  DUT address
- dut_wdata  in  NUM_CH x DATA_WIDTH  DUT write data
- sram_cs  out  NUM_CH  to SRAM
- sram_we  out  NUM_CH  to SRAM
- sram_addr  out  NUM_CH x ADDR_WIDTH  to SRAM
- sram_wdata  out  NUM_CH x DATA_WIDTH  to SRAM
- flip_arm  in  1  arm a bitflip
- flip_ch  in  CH_W  channel to arm
- flip_mask  in  DATA_WIDTH  XOR mask
- flip_pending  out  NUM_CH  armed and not yet consumed
- load_busy  out  1  session in progress
- load_done  out  1  one-cycle pulse at session end
- load_cnt  out  32  words drained this session

Behaviour:
- Reset (cptra_rst_b=0 at clk edge): FIFO flushed, FSM=IDLE, load_cnt=0, load_busy=0, load_done=0, flip_pending=0, masks=0. ext_ready=1 from the first cycle after reset.
- Mid-session reset drops buffered entries without writing them.
- Accept: push when ext_valid && ext_ready. ext_ready = !full, with no same-cycle pop credit.
- Drain:
  - Only the head entry is eligible; drain is strictly in order.
  - At most one drain per cycle.
  - Head for channel c is written that cycle iff dut_cs[c]==0; otherwise it stalls.
  - The DUT always has priority.
  - An entry pushed at cycle N is drained at N+1 at the earliest.
- SRAM mux, combinational per channel:
  - If dut_cs[c]: DUT signals pass through (wdata possibly flipped).
  - Else if draining to c: cs=1, we=1, head addr/data.
  - Else: all zero.
- load_cnt: increments per drained word and saturates at 0xFFFF_FFFF. Cleared on the IDLE->ACTIVE transition.
- FSM:
  - IDLE -> ACTIVE on first push.
  - ACTIVE -> FLUSH when a push carries ext_last. Pushes are still accepted in FLUSH but do not re-trigger.
  - FLUSH -> DONE when the FIFO is empty and the last entry is drained.
  - DONE -> IDLE unconditionally next cycle.
  - load_busy=1 in ACTIVE/FLUSH. load_done=1 in DONE only.
  - A push with ext_last in IDLE goes IDLE -> FLUSH directly.
- Simultaneous push and pop when full: no push (ready=0). When empty: no pop that cycle.
- DUT reads are never affected by the loader.

Optional Feature:
- Macro: CALIPTRA_SRAM_BITFLIP_INJ_EN.
- Enabled:
  - flip_arm loads mask[flip_ch] and sets flip_pending[flip_ch].
  - The next DUT write on that channel (dut_cs&dut_we) outputs dut_wdata^mask and clears pending.
  - Drain writes and DUT reads are never flipped.
  - Re-arming while pending overwrites the mask.
  - Arm in the same cycle as a consuming write: that write uses the old mask (if pending), and the new arm remains pending.
- Disabled: ports exist, flip_arm is ignored, flip_pending=0, wdata passes unmodified, and no mask registers are generated.

Decomposition:
- Package caliptra_sram_ldr_pkg contains:
  - entry struct {ch, addr, wdata, last}
  - FSM enum {IDLE, ACTIVE, FLUSH, DONE}
  - saturating-count constant
- Sub-module caliptra_sram_ldr_fifo: synchronous FIFO of entries exposing full/empty/head, with push/pop and the same sync reset.

Test Plan:
- Preload 8 words to ch0 (addr 0..7, ext_last on the 8th) with dut_cs idle -> sram writes at consecutive cycles starting 1 cycle after first push, load_cnt=8, load_done pulses once, load_busy low after.
- Hold dut_cs[1]=1 for 10 cycles with head targeting ch1 -> no loader write to ch1, ext_ready drops after 4 pushes, writes resume the cycle dut_cs[1] falls, order preserved.
- Interleave ch0/ch1 entries while DUT reads ch0 continuously -> ch1 entries drain only when at head; the DUT read data path is unaffected.
- Assert reset with 3 entries buffered -> no further sram writes, load_cnt=0, ext_ready=1 the cycle after reset release.
- (Macro on) arm ch0 mask=0x1, then DUT write 0x0 -> sram_wdata=0x1, pending clears. A second write of 0x0 passes as 0x0. A drain write while pending is unflipped.
- (Macro off) same stimulus -> sram_wdata=0x0, flip_pending stays 0.
